mux4_rr_arbiter: RTL

- Round-robin arbiter that shares one mux4 output channel among four requesters.
- Drives the 2-bit mux4 select (control) and a one-hot grant, and tracks ownership across cycles.
- Registered outputs only; control is held stable while idle so the downstream mux4 select never glitches.
- Sits between requester blocks and the shared mux4 datapath.

---
 rtl/mux4_rr_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving a shared mux4 select and one-hot grant (optional ARB_HOLD_LIMIT_EN)
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic             owner_release,
    output logic [1:0]       control,
    output logic [3:0]       grant,
    output logic             busy,
    output logic [CNT_W-1:0] hold_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    generate
        if (MAX_HOLD < 2 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_bad_max_hold
            $error("mux4_rr_arbiter: MAX_HOLD out of range for CNT_W");
        end
    endgenerate

    state_t           state;
    logic [1:0]       last;

    logic [3:0]       owner_mask;
    logic [3:0]       others;
    logic [3:0]       cand;
    logic             owner_req;
    logic             force_rel;
    logic             end_evt;
    logic [1:0]       winner;
    logic [1:0]       idx;
    logic             found;
    logic [CNT_W-1:0] hold_next;

    // In OWNED, control always names the owner, so it doubles as the owner index.
    always_comb begin
        owner_mask = 4'b0001 << control;
        owner_req  = |(req & owner_mask);
        others     = req & ~owner_mask;
`ifdef ARB_HOLD_LIMIT_EN
        force_rel  = (state == OWNED) && (hold_count == HOLD_LAST) && (others != 4'b0000);
`else
        force_rel  = 1'b0 & (hold_count == HOLD_LAST);
`endif
        end_evt    = owner_release | ~owner_req | force_rel;
        hold_next  = (&hold_count) ? hold_count : hold_count + CNT_W'(1);
    end

    // Circular scan last+1, last+2, last+3, last; the owner is already masked out of cand in OWNED.
    always_comb begin
        cand   = (state == IDLE) ? req : others;
        winner = last;
        found  = 1'b0;
        idx    = last;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && cand[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= 4'b0000;
            control    <= 2'b00;
            busy       <= 1'b0;
            hold_count <= '0;
            last       <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state      <= OWNED;
                        grant      <= 4'b0001 << winner;
                        control    <= winner;
                        busy       <= 1'b1;
                        last       <= winner;
                        hold_count <= '0;
                    end
                end
                OWNED: begin
                    if (!end_evt) begin
                        hold_count <= hold_next;
                    end else if (found) begin
                        grant      <= 4'b0001 << winner;
                        control    <= winner;
                        last       <= winner;
                        hold_count <= '0;
                    end else if (owner_release && owner_req) begin
                        hold_count <= '0;
                    end else begin
                        // control deliberately keeps the last owner's index.
                        state      <= IDLE;
                        grant      <= 4'b0000;
                        busy       <= 1'b0;
                        hold_count <= '0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    grant      <= 4'b0000;
                    busy       <= 1'b0;
                    hold_count <= '0;
                end
            endcase
        end
    end

endmodule
